// File: rtl/dmem_pipelined.sv
// Pipelined RV32 data memory: byte-lane steering, load formatting, fixed-latency in-order responses.
// Optional define DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into errors instead of aligning them.
module dmem_pipelined #(
  parameter int MEM_SIZE    = 1024,
  parameter int MEM_LATENCY = 1,
  parameter int RESP_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] BYTE_CAP = (ADDR_WIDTH + 1)'(MEM_SIZE) << 2;

  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W+1:0]  eff_addr;
  logic              align_err;
  logic              acc_err;
  logic [1:0]        offset;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        be;
  logic              wr_en;
  logic [31:0]       wdata_sh;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       fmt_data;
  logic [31:0]       resp_in_data;
  logic              arr_valid;
  logic [31:0]       arr_data;
  logic              arr_err;

  assign accept    = req_valid & req_ready;
  assign req_ready = !rst && (cnt_reg < CNT_W'(RESP_DEPTH));

  always_comb begin
    eff_addr  = req_addr[IDX_W+1:0];
    align_err = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    if (req_size == 2'd1)      align_err = req_addr[0];
    else if (req_size == 2'd2) align_err = |req_addr[1:0];
`else
    if (req_size == 2'd1)      eff_addr[0]   = 1'b0;
    else if (req_size == 2'd2) eff_addr[1:0] = 2'b00;
`endif
  end

  assign acc_err  = ({1'b0, req_addr} >= BYTE_CAP) | (req_size == 2'd3) | align_err;
  assign offset   = eff_addr[1:0];
  assign word_idx = eff_addr[IDX_W+1:2];
  assign wr_en    = accept & req_we & !acc_err;
  assign wdata_sh = req_wdata << {offset, 3'b000};

  always_comb begin
    be = 4'b0000;
    case (req_size)
      2'd0:    be = 4'b0001 << offset;
      2'd1:    be = 4'b0011 << offset;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // One byte-wide array per lane so each lane maps to its own RAM column.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_SIZE];
    always_ff @(posedge clk) begin
      if (wr_en && be[gi]) lane_mem[word_idx] <= wdata_sh[8*gi +: 8];
    end
    assign rd_word[8*gi +: 8] = lane_mem[word_idx];
  end

  assign shifted = rd_word >> {offset, 3'b000};

  always_comb begin
    fmt_data = 32'd0;
    case (req_size)
      2'd0:    fmt_data = req_unsigned ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    fmt_data = req_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      2'd2:    fmt_data = rd_word;
      default: fmt_data = 32'd0;
    endcase
  end

  assign resp_in_data = (acc_err || req_we) ? 32'd0 : fmt_data;

  if (MEM_LATENCY == 1) begin : g_bypass
    assign arr_valid = accept;
    assign arr_data  = resp_in_data;
    assign arr_err   = acc_err;
  end else begin : g_delay
    localparam int STAGES = MEM_LATENCY - 1;
    logic        dl_valid_reg [STAGES];
    logic [31:0] dl_data_reg  [STAGES];
    logic        dl_err_reg   [STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++) begin
          dl_valid_reg[i] <= 1'b0;
          dl_data_reg[i]  <= 32'd0;
          dl_err_reg[i]   <= 1'b0;
        end
      end else begin
        dl_valid_reg[0] <= accept;
        dl_data_reg[0]  <= resp_in_data;
        dl_err_reg[0]   <= acc_err;
        for (int i = 1; i < STAGES; i++) begin
          dl_valid_reg[i] <= dl_valid_reg[i-1];
          dl_data_reg[i]  <= dl_data_reg[i-1];
          dl_err_reg[i]   <= dl_err_reg[i-1];
        end
      end
    end

    assign arr_valid = dl_valid_reg[STAGES-1];
    assign arr_data  = dl_data_reg[STAGES-1];
    assign arr_err   = dl_err_reg[STAGES-1];
  end

  logic [31:0]           fifo_data_mem [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifo_err_reg;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_cnt_reg, fifo_cnt_next;

  assign resp_valid = (fifo_cnt_reg != '0);
  assign pop        = resp_valid & resp_ready;
  assign resp_rdata = resp_valid ? fifo_data_mem[rd_ptr_reg] : 32'd0;
  assign resp_err   = resp_valid & fifo_err_reg[rd_ptr_reg];

  // Credits cover in-flight requests, so an arrival always finds a free slot.
  always_ff @(posedge clk) begin
    if (arr_valid) begin
      fifo_data_mem[wr_ptr_reg] <= arr_data;
      fifo_err_reg[wr_ptr_reg]  <= arr_err;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({accept, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
    fifo_cnt_next = fifo_cnt_reg;
    case ({arr_valid, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      fifo_cnt_reg <= fifo_cnt_next;
      if (arr_valid) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)       rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule
